// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// default operand width, result field offsets and the divide-by-zero quotient.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Remainder sits in the upper half of the packed result and the quotient in the lower half.
    localparam int REM_LSB = 32;
    localparam int QUO_LSB = 0;

    localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract M,
// restore on a negative difference and shift the quotient bit into Q[0].
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    // One extra bit of headroom so the sign of the trial difference is exact.
    logic [WIDTH+1:0] a_shift;
    logic [WIDTH+1:0] diff;
    logic             neg;

    assign a_shift = {a, q[WIDTH-1]};
    assign diff    = a_shift - {2'b00, m};
    assign neg     = diff[WIDTH+1];
    assign a_next  = neg ? a_shift[WIDTH:0] : diff[WIDTH:0];

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_qshift
            assign q_next[gi] = q[gi-1];
        end
    endgenerate

    assign q_next[0] = ~neg;

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed restoring divider: one quotient bit per clock, with
// busy/done handshake, abort and divide-by-zero reporting.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_t state_reg, state_next;

    logic [WIDTH-1:0]   dividend_reg;
    logic [WIDTH-1:0]   divisor_reg;
    logic               sign_q_reg;
    logic               sign_r_reg;
    logic [WIDTH:0]     a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   m_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] result_reg;
    logic               div_zero_reg;

    logic [WIDTH:0]     a_step;
    logic [WIDTH-1:0]   q_step;
    logic [WIDTH-1:0]   abs_dividend;
    logic [WIDTH-1:0]   abs_divisor;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               divisor_zero;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_reg),
        .q      (q_reg),
        .m      (m_reg),
        .a_next (a_step),
        .q_next (q_step)
    );

    // Magnitudes are taken as unsigned, so the most negative value maps to 2^(WIDTH-1).
    assign abs_dividend = dividend_reg[WIDTH-1] ? (~dividend_reg + 1'b1) : dividend_reg;
    assign abs_divisor  = divisor_reg[WIDTH-1]  ? (~divisor_reg + 1'b1)  : divisor_reg;
    assign quo_fix      = sign_q_reg ? (~q_reg + 1'b1) : q_reg;
    assign rem_fix      = sign_r_reg ? (~a_reg[WIDTH-1:0] + 1'b1) : a_reg[WIDTH-1:0];
    assign divisor_zero = (divisor_reg == '0);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = PREP;
            end
            PREP: begin
                busy = 1'b1;
                if (abort)             state_next = IDLE;
                else if (divisor_zero) state_next = DONE;
                else                   state_next = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (abort)                     state_next = IDLE;
                else if (cnt_reg == CNT_LAST)  state_next = FIXUP;
            end
            FIXUP: begin
                busy = 1'b1;
                if (abort) state_next = IDLE;
                else       state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? PREP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            dividend_reg <= '0;
            divisor_reg  <= '0;
            sign_q_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            a_reg        <= '0;
            q_reg        <= '0;
            m_reg        <= '0;
            cnt_reg      <= '0;
            result_reg   <= '0;
            div_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        dividend_reg <= dividend;
                        divisor_reg  <= divisor;
                        sign_q_reg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r_reg   <= dividend[WIDTH-1];
                    end
                end
                PREP: begin
                    if (!abort) begin
                        if (divisor_zero) begin
                            result_reg[REM_LSB +: WIDTH] <= dividend_reg;
                            result_reg[QUO_LSB +: WIDTH] <= DZ_QUOTIENT;
                            div_zero_reg                 <= 1'b1;
                        end else begin
                            q_reg   <= abs_dividend;
                            m_reg   <= abs_divisor;
                            a_reg   <= '0;
                            cnt_reg <= '0;
                        end
                    end
                end
                ITER: begin
                    if (!abort) begin
                        a_reg   <= a_step;
                        q_reg   <= q_step;
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                FIXUP: begin
                    if (!abort) begin
                        result_reg[REM_LSB +: WIDTH] <= rem_fix;
                        result_reg[QUO_LSB +: WIDTH] <= quo_fix;
                        div_zero_reg                 <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result   = result_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl with hand-computed results.
module tb_div_seq_ctrl;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic        abort;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    div_seq_ctrl dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .abort    (abort),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one operation and waits (bounded) for done; optionally fires a
    // stray start request mid-operation that must be ignored.
    task automatic run_op(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                          input int exp_lat, input logic [63:0] exp_res, input logic exp_dz,
                          input bit glitch);
        int  n;
        int  busy_bad;
        bit  seen;
        @(negedge clk);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'hDEADBEEF;
        divisor  = 32'h0;
        n = 0;
        busy_bad = 0;
        seen = 1'b0;
        while (n < 60 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_bad++;
                if (glitch && n == 4) begin
                    start    = 1'b1;
                    dividend = 32'd1;
                    divisor  = 32'd1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                n++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check_eq({tag, "_busy_while_running"}, 64'(busy_bad), 64'd0);
        check_eq({tag, "_result"}, result, exp_res);
        check_eq({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
        check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        $display("op %s: %0d / %0d -> result=%h div_zero=%0b latency=%0d",
                 tag, $signed(dvd), $signed(dvs), result, div_zero, n);
        @(negedge clk);
        check_eq({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check_eq({tag, "_result_held"}, result, exp_res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        clr_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2;
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_div_zero", 64'(div_zero), 64'd0);
        check_eq("reset_result", result, 64'd0);
        repeat (3) @(negedge clk);
        clr_n = 1'b1;

        run_op("100_div_7",    32'd100,        32'd7,          34, 64'h00000002_0000000E, 1'b0, 1'b0);
        run_op("m100_div_7",   -32'sd100,      32'd7,          34, 64'hFFFFFFFE_FFFFFFF2, 1'b0, 1'b0);
        run_op("100_div_m7",   32'd100,        -32'sd7,        34, 64'h00000002_FFFFFFF2, 1'b0, 1'b1);
        run_op("m7_div_m2",    -32'sd7,        -32'sd2,        34, 64'hFFFFFFFF_00000003, 1'b0, 1'b0);
        run_op("5_div_0",      32'd5,          32'd0,           1, 64'h00000005_FFFFFFFF, 1'b1, 1'b0);
        run_op("9_div_3",      32'd9,          32'd3,          34, 64'h00000000_00000003, 1'b0, 1'b0);
        run_op("m5_div_0",     -32'sd5,        32'd0,           1, 64'hFFFFFFFB_FFFFFFFF, 1'b1, 1'b0);
        run_op("overflow",     32'h80000000,   32'hFFFFFFFF,   34, 64'h00000000_80000000, 1'b0, 1'b0);

        // Abort mid-operation, with a stray start at E5.
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b1; dividend = 32'd1; divisor = 32'd1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 6; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("abort_busy_before", 64'(busy), 64'd1);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy_after", 64'(busy), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check_eq("abort_no_done", 64'(done_seen), 64'd0);
        check_eq("abort_result_kept", result, 64'h00000000_80000000);
        $display("op abort: 100 / 7 aborted after E11, result=%h", result);

        run_op("50_div_6",     32'd50,         32'd6,          34, 64'h00000002_00000008, 1'b0, 1'b0);
        run_op("5_div_0_again", 32'd5,         32'd0,           1, 64'h00000005_FFFFFFFF, 1'b1, 1'b0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("midreset_busy_before", 64'(busy), 64'd1);
        #2 clr_n = 1'b0;
        #1;
        check_eq("midreset_busy", 64'(busy), 64'd0);
        check_eq("midreset_done", 64'(done), 64'd0);
        check_eq("midreset_div_zero", 64'(div_zero), 64'd0);
        check_eq("midreset_result", result, 64'd0);
        $display("op reset: 100 / 7 cleared at E20, result=%h", result);
        @(negedge clk);
        clr_n = 1'b1;

        run_op("7_div_2",      32'd7,          32'd2,          34, 64'h00000001_00000003, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
